// File: rtl/thr_pkg.sv
// Shared constants for the row-parallel threshold sequencer.
// Default geometry and the FSM state encoding.
package thr_pkg;

    localparam int COL_DEF      = 256;
    localparam int ROWS_DEF     = 256;
    localparam int WIDTH_DEF    = 8;
    localparam int FILT_LAT_DEF = 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Counter width for a range of n values, never narrower than 1 bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_pack_buffer.sv
// Row buffer: packs pixels in by index, unpacks them out by index,
// and takes a whole result row in one parallel load.
module row_pack_buffer
    import thr_pkg::*;
#(
    parameter int COL   = COL_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IW    = cw(COL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [IW-1:0]        i_wr_idx,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic                 i_ld_en,
    input  logic [COL*WIDTH-1:0] i_ld_row,
    input  logic [IW-1:0]        i_rd_idx,
    output logic [WIDTH-1:0]     o_rd_data,
    output logic [COL*WIDTH-1:0] o_row
);

    logic [WIDTH-1:0] r_mem [COL];

    // Storage: parallel load wins over a single-slot write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < COL; c++) begin
                r_mem[c] <= '0;
            end
        end else if (i_ld_en) begin
            for (int c = 0; c < COL; c++) begin
                r_mem[c] <= i_ld_row[c*WIDTH +: WIDTH];
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

    for (genvar g = 0; g < COL; g++) begin : g_pack
        assign o_row[g*WIDTH +: WIDTH] = r_mem[g];
    end

endmodule

// File: rtl/threshold_row_sequencer.sv
// Frame controller: fills a row, issues it to the threshold datapath,
// waits out its latency, captures the result and streams it out.
module threshold_row_sequencer
    import thr_pkg::*;
#(
    parameter int COL      = COL_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int FILT_LAT = FILT_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic [COL*WIDTH-1:0]  flt_row_in,
    output logic                  flt_en,
    input  logic [COL*WIDTH-1:0]  flt_row_out,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [cw(ROWS)-1:0]   row_idx
);

    localparam int CW = cw(COL);
    localparam int RW = cw(ROWS);
    localparam int LW = cw(FILT_LAT + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(FILT_LAT - 1);

    logic [2:0]       r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [LW-1:0]    r_lat;

    logic             w_fill;
    logic             w_drain;
    logic             w_wr_en;
    logic             w_ld_en;
    logic             w_col_end;
    logic [WIDTH-1:0] w_rd_data;

    assign w_fill    = (r_state == ST_FILL);
    assign w_drain   = (r_state == ST_DRAIN);
    assign w_wr_en   = w_fill & in_valid;
    assign w_ld_en   = (r_state == ST_WAIT) & (r_lat == LAT_LAST);
    assign w_col_end = (r_col == COL_LAST);

    // Sequencing of a frame: one row in flight at a time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_lat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FILL;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        if (w_col_end) begin
                            r_col   <= '0;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_lat   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (w_col_end) begin
                            r_col <= '0;
                            if (r_row == ROW_LAST) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_row   <= r_row + 1'b1;
                                r_state <= ST_FILL;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    row_pack_buffer #(
        .COL   (COL),
        .WIDTH (WIDTH),
        .IW    (CW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_col),
        .i_wr_data (in_data),
        .i_ld_en   (w_ld_en),
        .i_ld_row  (flt_row_out),
        .i_rd_idx  (r_col),
        .o_rd_data (w_rd_data),
        .o_row     (flt_row_in)
    );

    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_DONE);
    assign in_ready   = w_fill;
    assign flt_en     = (r_state == ST_ISSUE);
    assign out_valid  = w_drain;
    assign out_data   = w_drain ? w_rd_data : '0;
    assign out_last   = w_drain & w_col_end;
    assign row_idx    = r_row;

endmodule
